// File: rtl/smem_rsp_merger_if.sv
// rtl/smem_rsp_merger_if.sv - alloc, beat-in and merged-out channels of smem_rsp_merger
// Perf counter signals exist only when SMEM_RSP_MERGE_PERF_EN is defined.
interface smem_rsp_merger_if #(
  parameter int NUM_REQS       = 4,
  parameter int WORD_SIZE      = 4,
  parameter int CORE_TAG_WIDTH = 10,
  parameter int TAG_IDX_BITS   = 4
);
  localparam int DW = NUM_REQS * 8 * WORD_SIZE;
  localparam int CW = $clog2((1 << TAG_IDX_BITS) + 1);

  logic                      alloc_valid;
  logic [CORE_TAG_WIDTH-1:0] alloc_tag;
  logic [NUM_REQS-1:0]       alloc_mask;
  logic                      alloc_ready;

  logic                      rsp_in_valid;
  logic [NUM_REQS-1:0]       rsp_in_tmask;
  logic [DW-1:0]             rsp_in_data;
  logic [CORE_TAG_WIDTH-1:0] rsp_in_tag;
  logic                      rsp_in_ready;

  logic                      rsp_out_valid;
  logic [NUM_REQS-1:0]       rsp_out_tmask;
  logic [DW-1:0]             rsp_out_data;
  logic [CORE_TAG_WIDTH-1:0] rsp_out_tag;
  logic                      rsp_out_ready;

  logic [CW-1:0]             pending_count;
  logic                      err;
`ifdef SMEM_RSP_MERGE_PERF_EN
  logic [31:0]               perf_partial_beats;
  logic [31:0]               perf_merged_rsps;
  logic [31:0]               perf_out_stalls;
`endif

  modport master (
    output alloc_valid, alloc_tag, alloc_mask,
    input  alloc_ready,
    output rsp_in_valid, rsp_in_tmask, rsp_in_data, rsp_in_tag,
    input  rsp_in_ready,
    input  rsp_out_valid, rsp_out_tmask, rsp_out_data, rsp_out_tag,
    output rsp_out_ready,
`ifdef SMEM_RSP_MERGE_PERF_EN
    input  perf_partial_beats, perf_merged_rsps, perf_out_stalls,
`endif
    input  pending_count, err
  );

  modport slave (
    input  alloc_valid, alloc_tag, alloc_mask,
    output alloc_ready,
    input  rsp_in_valid, rsp_in_tmask, rsp_in_data, rsp_in_tag,
    output rsp_in_ready,
    output rsp_out_valid, rsp_out_tmask, rsp_out_data, rsp_out_tag,
    input  rsp_out_ready,
`ifdef SMEM_RSP_MERGE_PERF_EN
    output perf_partial_beats, perf_merged_rsps, perf_out_stalls,
`endif
    output pending_count, err
  );
endinterface

// File: rtl/smem_rsp_merger.sv
// rtl/smem_rsp_merger.sv - merges split shared-memory response beats into one response per tag
// Optional perf counters enabled by SMEM_RSP_MERGE_PERF_EN.
module smem_rsp_merger #(
  parameter int NUM_REQS       = 4,
  parameter int WORD_SIZE      = 4,
  parameter int CORE_TAG_WIDTH = 10,
  parameter int TAG_IDX_BITS   = 4
) (
  input  logic             clk,
  input  logic             reset,
  smem_rsp_merger_if.slave bus
);
  localparam int ENTRIES = 1 << TAG_IDX_BITS;
  localparam int LW      = 8 * WORD_SIZE;
  localparam int DW      = NUM_REQS * LW;
  localparam int CW      = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0]        r_busy;
  logic [NUM_REQS-1:0]       r_exp  [ENTRIES];
  logic [NUM_REQS-1:0]       r_rcv  [ENTRIES];
  logic [CORE_TAG_WIDTH-1:0] r_tag  [ENTRIES];
  logic [DW-1:0]             r_data [ENTRIES];

  logic                      r_out_valid;
  logic [NUM_REQS-1:0]       r_out_tmask;
  logic [DW-1:0]             r_out_data;
  logic [CORE_TAG_WIDTH-1:0] r_out_tag;
  logic [CW-1:0]             r_pending;
  logic                      r_err;

  logic [TAG_IDX_BITS-1:0]   w_aidx;
  logic [TAG_IDX_BITS-1:0]   w_ridx;
  logic                      w_alloc_ready;
  logic                      w_alloc_fire;
  logic                      w_in_ready;
  logic                      w_rsp_fire;
  logic                      w_rsp_bad;
  logic                      w_rsp_good;
  logic                      w_complete;
  logic [NUM_REQS-1:0]       w_merged_mask;
  logic [DW-1:0]             w_merged_data;

  assign w_aidx        = bus.alloc_tag[TAG_IDX_BITS-1:0];
  assign w_ridx        = bus.rsp_in_tag[TAG_IDX_BITS-1:0];
  assign w_alloc_ready = (bus.alloc_mask == '0) | ~r_busy[w_aidx];
  assign w_alloc_fire  = bus.alloc_valid & w_alloc_ready & (bus.alloc_mask != '0);
  assign w_in_ready    = ~r_out_valid | bus.rsp_out_ready;
  assign w_rsp_fire    = bus.rsp_in_valid & w_in_ready;

  // Any malformed beat is swallowed without touching the table.
  assign w_rsp_bad = w_rsp_fire & (~r_busy[w_ridx]
                                   | (bus.rsp_in_tmask == '0)
                                   | ((bus.rsp_in_tmask & r_rcv[w_ridx]) != '0)
                                   | ((bus.rsp_in_tmask & ~r_exp[w_ridx]) != '0)
                                   | (bus.rsp_in_tag != r_tag[w_ridx]));
  assign w_rsp_good    = w_rsp_fire & ~w_rsp_bad;
  assign w_merged_mask = r_rcv[w_ridx] | bus.rsp_in_tmask;
  assign w_complete    = w_rsp_good & (w_merged_mask == r_exp[w_ridx]);

  always_comb begin
    w_merged_data = r_data[w_ridx];
    for (int l = 0; l < NUM_REQS; l++) begin
      if (bus.rsp_in_tmask[l]) w_merged_data[l*LW +: LW] = bus.rsp_in_data[l*LW +: LW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_pending   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_alloc_fire) r_busy[w_aidx] <= 1'b1;
      if (w_complete)   r_busy[w_ridx] <= 1'b0;
      if (w_rsp_bad)    r_err <= 1'b1;
      if (w_complete)              r_out_valid <= 1'b1;
      else if (bus.rsp_out_ready)  r_out_valid <= 1'b0;
      r_pending <= r_pending + CW'(w_alloc_fire) - CW'(w_complete);
    end
  end

  // Payload needs no reset: busy and output-valid gate every use of it.
  always_ff @(posedge clk) begin
    if (w_alloc_fire) begin
      r_exp[w_aidx] <= bus.alloc_mask;
      r_rcv[w_aidx] <= '0;
      r_tag[w_aidx] <= bus.alloc_tag;
    end
    if (w_rsp_good) begin
      r_rcv[w_ridx]  <= w_merged_mask;
      r_data[w_ridx] <= w_merged_data;
    end
    if (w_complete) begin
      r_out_tmask <= r_exp[w_ridx];
      r_out_data  <= w_merged_data;
      r_out_tag   <= r_tag[w_ridx];
    end
  end

`ifdef SMEM_RSP_MERGE_PERF_EN
  logic [31:0] r_perf_partial;
  logic [31:0] r_perf_merged;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_partial <= '0;
      r_perf_merged  <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_rsp_good & ~w_complete) r_perf_partial <= r_perf_partial + 32'd1;
      if (w_complete & (r_rcv[w_ridx] != '0)) r_perf_merged <= r_perf_merged + 32'd1;
      if (r_out_valid & ~bus.rsp_out_ready) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign bus.perf_partial_beats = r_perf_partial;
  assign bus.perf_merged_rsps   = r_perf_merged;
  assign bus.perf_out_stalls    = r_perf_stalls;
`endif

  assign bus.alloc_ready   = w_alloc_ready;
  assign bus.rsp_in_ready  = w_in_ready;
  assign bus.rsp_out_valid = r_out_valid;
  assign bus.rsp_out_tmask = r_out_tmask;
  assign bus.rsp_out_data  = r_out_data;
  assign bus.rsp_out_tag   = r_out_tag;
  assign bus.pending_count = r_pending;
  assign bus.err           = r_err;
endmodule

// File: tb/tb_smem_rsp_merger.sv
// tb/tb_smem_rsp_merger.sv - randomized bench for smem_rsp_merger against a tag-table model
module tb_smem_rsp_merger;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  smem_rsp_merger_if bus ();
  smem_rsp_merger dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0]   tmask;
    logic [9:0]   tag;
    logic [127:0] data;
  } rsp_t;

  bit         m_busy [16];
  logic [3:0] m_exp  [16];
  logic [3:0] m_rcv  [16];
  logic [9:0] m_tag  [16];
  logic [31:0] m_data [16][4];
  rsp_t       oq[$];
  int         m_cnt;
  bit         m_err;

  int   n_checks = 0;
  int   n_pass = 0;
  logic s_ar, s_ir;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic idle(bit ordy = 1'b1);
    bus.alloc_valid   = 1'b0;
    bus.alloc_tag     = '0;
    bus.alloc_mask    = '0;
    bus.rsp_in_valid  = 1'b0;
    bus.rsp_in_tmask  = '0;
    bus.rsp_in_data   = '0;
    bus.rsp_in_tag    = '0;
    bus.rsp_out_ready = ordy;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = 1'b0;
      m_rcv[i]  = '0;
    end
    oq.delete();
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // One clock: check readies, advance model over the edge, then check registered outputs.
  task automatic step();
    bit afire, hs, rfire, bad;
    logic [3:0] tm, mg;
    int ai, ri;
    rsp_t r;
    #1;
    ai = int'(bus.alloc_tag[3:0]);
    ri = int'(bus.rsp_in_tag[3:0]);
    s_ar = bus.alloc_ready;
    s_ir = bus.rsp_in_ready;
    chk("alloc_ready", s_ar, (bus.alloc_mask == 0) || !m_busy[ai]);
    chk("rsp_in_ready", s_ir, (oq.size() == 0) || bus.rsp_out_ready);
    afire = bus.alloc_valid && (bus.alloc_mask != 0) && !m_busy[ai];
    hs    = (oq.size() != 0) && bus.rsp_out_ready;
    rfire = bus.rsp_in_valid && ((oq.size() == 0) || bus.rsp_out_ready);
    tm    = bus.rsp_in_tmask;
    @(posedge clk);
    if (hs) void'(oq.pop_front());
    if (rfire) begin
      bad = !m_busy[ri] || tm == 0 || (tm & m_rcv[ri]) != 0 || (tm & ~m_exp[ri]) != 0
            || bus.rsp_in_tag != m_tag[ri];
      if (bad) m_err = 1'b1;
      else begin
        for (int l = 0; l < 4; l++)
          if (tm[l]) m_data[ri][l] = bus.rsp_in_data[l*32 +: 32];
        mg = m_rcv[ri] | tm;
        if (mg == m_exp[ri]) begin
          r.tmask = m_exp[ri];
          r.tag   = m_tag[ri];
          for (int l = 0; l < 4; l++) r.data[l*32 +: 32] = m_data[ri][l];
          oq.push_back(r);
          m_busy[ri] = 1'b0;
          m_cnt--;
        end else m_rcv[ri] = mg;
      end
    end
    if (afire) begin
      m_busy[ai] = 1'b1;
      m_exp[ai]  = bus.alloc_mask;
      m_rcv[ai]  = '0;
      m_tag[ai]  = bus.alloc_tag;
      m_cnt++;
    end
    @(negedge clk);
    chk("rsp_out_valid", bus.rsp_out_valid, oq.size() != 0);
    if (bus.rsp_out_valid && oq.size() != 0) begin
      chk("rsp_out_tag", bus.rsp_out_tag, oq[0].tag);
      chk("rsp_out_tmask", bus.rsp_out_tmask, oq[0].tmask);
      for (int l = 0; l < 4; l++)
        if (oq[0].tmask[l]) chk("rsp_out_data", bus.rsp_out_data[l*32 +: 32], oq[0].data[l*32 +: 32]);
    end
    chk("pending_count", bus.pending_count, m_cnt);
    chk("err", bus.err, m_err);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    chk("reset_valid", bus.rsp_out_valid, 1'b0);
    chk("reset_pending", bus.pending_count, 0);
    chk("reset_err", bus.err, 1'b0);
  endtask

  task automatic alloc(logic [9:0] tag, logic [3:0] mask);
    idle();
    bus.alloc_valid = 1'b1;
    bus.alloc_tag   = tag;
    bus.alloc_mask  = mask;
  endtask

  task automatic beat(logic [9:0] tag, logic [3:0] tm, logic [127:0] d);
    bus.rsp_in_valid = 1'b1;
    bus.rsp_in_tag   = tag;
    bus.rsp_in_tmask = tm;
    bus.rsp_in_data  = d;
  endtask

  task automatic rand_cycle(bit allow_bad);
    int i;
    logic [3:0] rem, sub;
    idle($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 2) == 0) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_tag   = 10'($urandom_range(0, 1023));
      bus.alloc_mask  = 4'($urandom_range(0, 15));
    end
    i = $urandom_range(0, 15);
    if (allow_bad && $urandom_range(0, 9) == 0) begin
      beat(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)),
           {$urandom, $urandom, $urandom, $urandom});
    end else if (m_busy[i] && $urandom_range(0, 4) != 0) begin
      rem = m_exp[i] & ~m_rcv[i];
      sub = rem & 4'($urandom_range(0, 15));
      if (sub == 0) sub = rem & (~rem + 4'd1);
      beat(m_tag[i], sub, {$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  initial begin
    clear_model();
    idle();
    @(negedge clk);
    do_reset();

    // Single full beat completes with one cycle of latency.
    alloc(10'h005, 4'b1111); step();
    chk("t1_pending_up", bus.pending_count, 1);
    idle(); beat(10'h005, 4'b1111, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0); step();
    chk("t1_valid", bus.rsp_out_valid, 1'b1);
    chk("t1_tag", bus.rsp_out_tag, 10'h005);
    chk("t1_data", bus.rsp_out_data, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0);
    chk("t1_pending_down", bus.pending_count, 0);
    idle(); step();

    // Two partial beats merge into one response.
    alloc(10'h013, 4'b1011); step();
    idle(); beat(10'h013, 4'b0001, 128'h0_0_0_000000A0); step();
    chk("t2_no_early_out", bus.rsp_out_valid, 1'b0);
    idle(); beat(10'h013, 4'b1010, 128'h000000B3_00000000_000000B1_00000000); step();
    chk("t2_tmask", bus.rsp_out_tmask, 4'b1011);
    chk("t2_lane0", bus.rsp_out_data[31:0], 32'hA0);
    chk("t2_lane1", bus.rsp_out_data[63:32], 32'hB1);
    chk("t2_lane3", bus.rsp_out_data[127:96], 32'hB3);
    idle(); step();

    // Output back-pressure holds the register and blocks beats.
    alloc(10'h021, 4'b0001); step();
    idle(1'b0); beat(10'h021, 4'b0001, 128'h55); step();
    idle(1'b0); step();
    chk("t3_in_blocked", s_ir, 1'b0);
    idle(1'b0); step();
    chk("t3_held_tag", bus.rsp_out_tag, 10'h021);
    idle(1'b1); step();
    chk("t3_in_released", s_ir, 1'b1);
    chk("t3_drained", bus.rsp_out_valid, 1'b0);

    // Alloc to an index whose entry completes this cycle is blocked until next cycle.
    alloc(10'h007, 4'b1111); step();
    alloc(10'h007, 4'b1111); beat(10'h007, 4'b1111, 128'h7); step();
    chk("t4_blocked", s_ar, 1'b0);
    alloc(10'h007, 4'b0011); step();
    chk("t4_realloc", s_ar, 1'b1);
    chk("t4_pending", bus.pending_count, 1);
    idle(); beat(10'h007, 4'b0011, 128'h77); step();
    idle(); step();

    // Write-only request.
    alloc(10'h00A, 4'b0000); step();
    chk("t5_ready", s_ar, 1'b1);
    chk("t5_pending", bus.pending_count, 0);
    idle(); step(); step();

    // Protocol errors, then reset clears them and any half-built entry.
    idle(); beat(10'h009, 4'b0001, 128'h9); step();
    chk("t6_err", bus.err, 1'b1);
    alloc(10'h013, 4'b1011); step();
    idle(); beat(10'h013, 4'b0001, 128'h1); step();
    idle(); beat(10'h013, 4'b0001, 128'h1); step();
    chk("t6_pending_kept", bus.pending_count, 1);
    do_reset();
    idle(); beat(10'h013, 4'b1010, 128'h2); step();
    chk("t6_discarded", bus.err, 1'b1);
    do_reset();

    for (int c = 0; c < 3000; c++) begin
      rand_cycle(1'b0);
      step();
    end
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      rand_cycle(1'b1);
      step();
    end
    idle(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
